// File: rtl/mvm_uart_system.sv
// UART-attached signed matrix-vector multiplier: receives x and K as a byte
// stream, computes y = K*x with one MAC per row and returns y over TX.
module mvm_uart_system #(
  parameter int CLOCKS_PER_PULSE = 20833,
  parameter int BITS_PER_WORD    = 8,
  parameter int PACKET_SIZE_TX   = BITS_PER_WORD + 5,
  parameter int R                = 4,
  parameter int C                = 4,
  parameter int W_X              = 8,
  parameter int W_K              = 8,
  parameter int W_Y_OUT          = 32
) (
  input  logic clk,
  input  logic rstn,
  input  logic rx,
  output logic tx
);

  localparam int W_Y        = W_X + W_K + $clog2(C);
  localparam int W_P        = W_X + W_K;
  localparam int W_BUS_KX   = R*C*W_K + C*W_X;
  localparam int N_WORDS_KX = W_BUS_KX / BITS_PER_WORD;
  localparam int W_BUS_Y    = R*W_Y_OUT;
  localparam int N_WORDS_Y  = W_BUS_Y / BITS_PER_WORD;

  localparam int W_CNT   = $clog2(CLOCKS_PER_PULSE);
  localparam int W_RXBIT = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
  localparam int W_BYTE  = (N_WORDS_KX > 1) ? $clog2(N_WORDS_KX) : 1;
  localparam int W_COL   = (C > 1) ? $clog2(C) : 1;
  localparam int W_TXBIT = $clog2(PACKET_SIZE_TX);
  localparam int W_WORD  = (N_WORDS_Y > 1) ? $clog2(N_WORDS_Y) : 1;

  localparam logic [W_CNT-1:0]   CNT_FULL    = W_CNT'(CLOCKS_PER_PULSE - 1);
  localparam logic [W_CNT-1:0]   CNT_HALF    = W_CNT'(CLOCKS_PER_PULSE/2 - 1);
  localparam logic [W_RXBIT-1:0] LAST_RXBIT  = W_RXBIT'(BITS_PER_WORD - 1);
  localparam logic [W_BYTE-1:0]  LAST_BYTE   = W_BYTE'(N_WORDS_KX - 1);
  localparam logic [W_COL-1:0]   LAST_COL    = W_COL'(C - 1);
  localparam logic [W_TXBIT-1:0] LAST_TXBIT  = W_TXBIT'(PACKET_SIZE_TX - 1);
  localparam logic [W_WORD-1:0]  LAST_WORD   = W_WORD'(N_WORDS_Y - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {ENG_IDLE, ENG_MAC, ENG_LOAD, ENG_TX} eng_state_t;

  rx_state_t                rx_state;
  logic                     rx_meta;
  logic                     rx_sync;
  logic [W_CNT-1:0]         rx_cnt;
  logic [W_RXBIT-1:0]       rx_bit;
  logic [BITS_PER_WORD-1:0] rx_shift;
  logic [W_BYTE-1:0]        byte_cnt;
  logic [W_BUS_KX-1:0]      kx_shift;
  logic                     bus_done;

  eng_state_t               eng_state;
  logic [W_BUS_KX-1:0]      hold_bus;
  logic                     hold_valid;
  logic [W_BUS_KX-1:0]      work_bus;
  logic [W_COL-1:0]         col;
  logic signed [W_Y-1:0]    acc [R];
  logic [W_BUS_Y-1:0]       y_bus;
  logic [W_CNT-1:0]         tx_cnt;
  logic [W_TXBIT-1:0]       tx_bit;
  logic [W_WORD-1:0]        tx_word;

  logic signed [W_X-1:0]    x_arr [C];
  logic signed [W_K-1:0]    k_arr [R][C];
  logic signed [W_P-1:0]    x_ext;
  logic signed [W_P-1:0]    prod [R];
  logic [PACKET_SIZE_TX-1:0] frame;

  // Bytes enter at the top of kx_shift, so after the last byte byte 0 sits at the LSB.
  always_ff @(posedge clk) begin
    if (rstn) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      byte_cnt <= '0;
      kx_shift <= '0;
      bus_done <= 1'b0;
    end else begin
      rx_meta  <= rx;
      rx_sync  <= rx_meta;
      bus_done <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (!rx_sync) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == CNT_HALF) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == CNT_FULL) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[BITS_PER_WORD-1:1]};
            if (rx_bit == LAST_RXBIT) rx_state <= RX_STOP;
            else                      rx_bit   <= rx_bit + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == CNT_FULL) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rx_sync) begin
              kx_shift <= {rx_shift, kx_shift[W_BUS_KX-1:BITS_PER_WORD]};
              if (byte_cnt == LAST_BYTE) begin
                byte_cnt <= '0;
                bus_done <= 1'b1;
              end else begin
                byte_cnt <= byte_cnt + 1'b1;
              end
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  for (genvar c = 0; c < C; c++) begin : g_x
    assign x_arr[c] = work_bus[c*W_X +: W_X];
  end

  for (genvar r = 0; r < R; r++) begin : g_row
    logic signed [W_P-1:0] k_ext;
    for (genvar c = 0; c < C; c++) begin : g_col
      assign k_arr[r][c] = work_bus[C*W_X + (r*C + c)*W_K +: W_K];
    end
    assign k_ext   = W_P'(k_arr[r][col]);
    assign prod[r] = k_ext * x_ext;
  end

  assign x_ext = W_P'(x_arr[col]);
  assign frame = {{(PACKET_SIZE_TX-BITS_PER_WORD-1){1'b1}}, y_bus[BITS_PER_WORD-1:0], 1'b0};

  // A newly completed bus always lands in the holding register, even while one is being taken.
  always_ff @(posedge clk) begin
    if (rstn) begin
      eng_state  <= ENG_IDLE;
      hold_bus   <= '0;
      hold_valid <= 1'b0;
      work_bus   <= '0;
      col        <= '0;
      for (int r = 0; r < R; r++) acc[r] <= '0;
      y_bus      <= '0;
      tx_cnt     <= '0;
      tx_bit     <= '0;
      tx_word    <= '0;
      tx         <= 1'b1;
    end else begin
      tx <= 1'b1;
      case (eng_state)
        ENG_IDLE: begin
          if (hold_valid) begin
            work_bus   <= hold_bus;
            hold_valid <= 1'b0;
            col        <= '0;
            for (int r = 0; r < R; r++) acc[r] <= '0;
            eng_state  <= ENG_MAC;
          end
        end
        ENG_MAC: begin
          for (int r = 0; r < R; r++) acc[r] <= acc[r] + W_Y'(prod[r]);
          if (col == LAST_COL) eng_state <= ENG_LOAD;
          else                 col       <= col + 1'b1;
        end
        ENG_LOAD: begin
          for (int r = 0; r < R; r++) y_bus[r*W_Y_OUT +: W_Y_OUT] <= W_Y_OUT'(acc[r]);
          tx_cnt    <= '0;
          tx_bit    <= '0;
          tx_word   <= '0;
          eng_state <= ENG_TX;
        end
        ENG_TX: begin
          tx <= frame[tx_bit];
          if (tx_cnt == CNT_FULL) begin
            tx_cnt <= '0;
            if (tx_bit == LAST_TXBIT) begin
              tx_bit <= '0;
              y_bus  <= y_bus >> BITS_PER_WORD;
              if (tx_word == LAST_WORD) eng_state <= ENG_IDLE;
              else                      tx_word   <= tx_word + 1'b1;
            end else begin
              tx_bit <= tx_bit + 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: eng_state <= ENG_IDLE;
      endcase
      if (bus_done) begin
        hold_bus   <= kx_shift;
        hold_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mvm_uart_system.sv
// Scoreboard bench for mvm_uart_system: a UART driver feeds x/K streams while
// an independent TX decoder pops expected bytes from a queue and compares.
module tb_mvm_uart_system;

  localparam int CPP   = 4;
  localparam int R     = 4;
  localparam int C     = 4;
  localparam int NKX   = R*C + C;
  localparam int STOPS = 4;

  logic clk = 1'b0;
  logic rstn;
  logic rx;
  logic tx;

  always #5 clk = ~clk;

  mvm_uart_system #(
    .CLOCKS_PER_PULSE(CPP),
    .BITS_PER_WORD   (8),
    .PACKET_SIZE_TX  (13),
    .R               (R),
    .C               (C),
    .W_X             (8),
    .W_K             (8),
    .W_Y_OUT         (32)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .rx  (rx),
    .tx  (tx)
  );

  int n_compared   = 0;
  int n_mismatched = 0;
  int frames_seen  = 0;
  logic [7:0] exp_q[$];

  byte cur_x[C];
  byte cur_k[R][C];

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_compared++;
    if (actual != expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference: y[r] = sum_c K[r][c]*x[c] in plain integer arithmetic, sent LSB byte first.
  task automatic push_expected();
    for (int r = 0; r < R; r++) begin
      int y = 0;
      for (int c = 0; c < C; c++) y += int'(cur_k[r][c]) * int'(cur_x[c]);
      for (int b = 0; b < 4; b++) exp_q.push_back(8'((y >> (8*b)) & 255));
    end
  endtask

  task automatic push_word_repeated(input logic [31:0] w, input int times);
    for (int i = 0; i < times; i++)
      for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
  endtask

  task automatic randomize_vector();
    for (int c = 0; c < C; c++) cur_x[c] = byte'($urandom_range(0, 255));
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) cur_k[r][c] = byte'($urandom_range(0, 255));
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    rx = 1'b0;
    repeat (CPP) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPP) @(negedge clk);
    end
    rx = good_stop;
    repeat (CPP) @(negedge clk);
    rx = 1'b1;
  endtask

  // Sends x then K row-major; bad_idx >= 0 first sends that byte corrupted with a 0 stop bit.
  task automatic applyStimulus(input int bad_idx, input int max_gap);
    for (int i = 0; i < NKX; i++) begin
      logic [7:0] b;
      b = (i < C) ? 8'(cur_x[i]) : 8'(cur_k[(i-C)/C][(i-C)%C]);
      if (i == bad_idx) begin
        send_byte(~b, 1'b0);
        repeat (3*CPP) @(negedge clk);
      end
      send_byte(b, 1'b1);
      if (max_gap > 0) repeat ($urandom_range(1, max_gap)) @(negedge clk);
    end
  endtask

  task automatic wait_drain(input int budget);
    int t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    checkOutput("drain_remaining", exp_q.size(), 0);
  endtask

  // TX decoder: samples each bit at mid-period on the negative edge.
  initial begin : monitor
    logic [7:0] d;
    bit frame_ok;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        repeat (CPP/2) @(negedge clk);
        frame_ok = (tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPP) @(negedge clk);
          d[i] = tx;
        end
        for (int s = 0; s < STOPS; s++) begin
          repeat (CPP) @(negedge clk);
          if (tx !== 1'b1) frame_ok = 1'b0;
        end
        frames_seen++;
        checkOutput("tx_framing", int'(frame_ok), 1);
        if (exp_q.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL unexpected_tx_byte: got 0x%0h, expected no byte", d);
        end else begin
          checkOutput("tx_byte", int'(d), int'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, %0d bytes still expected", exp_q.size());
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    rx   = 1'b1;
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("tx_during_reset", int'(tx), 1);
    end
    rstn = 1'b0;
    repeat (200) @(negedge clk);
    checkOutput("frames_after_idle_reset", frames_seen, 0);
    checkOutput("tx_idle_high", int'(tx), 1);

    $display("[TB] basic vector");
    cur_x = '{8'sd10, 8'sd11, 8'sd12, 8'sd13};
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) cur_k[r][c] = (r == 0) ? byte'(c + 1) : 8'sd0;
    push_word_repeated(32'd120, 1);
    push_word_repeated(32'd0, 3);
    applyStimulus(-1, 0);
    wait_drain(4000);

    $display("[TB] signed vector");
    for (int c = 0; c < C; c++) cur_x[c] = -8'sd1;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) cur_k[r][c] = 8'sd127;
    push_word_repeated(32'hFFFF_FE04, 4);
    applyStimulus(-1, 0);
    wait_drain(4000);

    $display("[TB] extreme vector");
    for (int c = 0; c < C; c++) cur_x[c] = -8'sd128;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) cur_k[r][c] = -8'sd128;
    push_word_repeated(32'h0001_0000, 4);
    applyStimulus(-1, 0);
    wait_drain(4000);

    $display("[TB] two back-to-back random vectors with gaps");
    randomize_vector();
    push_expected();
    applyStimulus(-1, 20);
    randomize_vector();
    push_expected();
    applyStimulus(-1, 20);
    wait_drain(8000);

    $display("[TB] bad stop bit on byte 5 then resend");
    randomize_vector();
    push_expected();
    applyStimulus(5, 0);
    wait_drain(4000);

    $display("[TB] further random vectors");
    for (int n = 0; n < 3; n++) begin
      randomize_vector();
      push_expected();
      applyStimulus(-1, 5);
      wait_drain(5000);
    end

    repeat (100) @(negedge clk);
    checkOutput("tx_idle_at_end", int'(tx), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/mvm_uart_system.md
Name: mvm_uart_system

Overview:
UART-attached matrix-vector multiplier. It receives a packed signed vector x (C elements) and matrix K (R×C) as a byte stream on a serial RX line, computes y = K·x in signed arithmetic, and returns the R results, each sign-extended to W_Y_OUT bits, as a byte stream on a serial TX line. It is a standalone top-level block between the host UART pins and the compute core.

Parameters:
CLOCKS_PER_PULSE, 20833, clock cycles per UART bit (the bench uses 4).
BITS_PER_WORD, 8, data bits per UART frame.
PACKET_SIZE_TX, BITS_PER_WORD+5, total TX frame bits: 1 start, BITS_PER_WORD data, rest stop/idle ones.
R, 4, matrix rows / number of outputs.
C, 4, matrix columns / vector length.
W_X, 8, signed x element width.
W_K, 8, signed K element width.
W_Y_OUT, 32, transmitted width per output.
Derived values:
- W_Y = W_X+W_K+$clog2(C)
- W_BUS_KX = R*C*W_K + C*W_X
- N_WORDS_KX = W_BUS_KX/BITS_PER_WORD (20 at defaults)
- N_WORDS_Y = R*W_Y_OUT/BITS_PER_WORD (16 at defaults)
- Both divisions must be exact.

Ports:
clk  in  1  system clock, all logic on rising edge.
rstn  in  1  reset, synchronous, active-high: reset is asserted while rstn=1.
rx  in  1  UART serial input, idle high.
tx  out  1  UART serial output, idle high.

Behaviour:
- Reset: tx=1; all bit, byte and state counters cleared; partial input or output discarded; RX and TX FSMs go to IDLE.
- RX frame: 8N1, LSB first, CLOCKS_PER_PULSE clocks per bit.
  - In IDLE, rx=0 starts a frame.
  - Bit sampling occurs at mid-bit (CLOCKS_PER_PULSE/2 after the start edge, then every CLOCKS_PER_PULSE).
  - If rx is high at the start-bit mid-sample, the frame is aborted (glitch) and RX returns to IDLE.
  - If the stop bit samples as 0, the byte is discarded and the byte counter does not advance.
  - Back-to-back frames with arbitrary idle gaps are accepted.
- Input packing:
  - Received byte i fills bits [8i+7:8i] of the W_BUS_KX input bus.
  - Bus layout, LSB first: x[0..C-1] (W_X each), then K row-major, with K[r][c] at offset C*W_X + (r*C+c)*W_K.
- Compute trigger: when byte N_WORDS_KX-1 is stored, the bus is latched and the byte counter wraps to 0.
- Compute: y[r] = Σ_c signed(K[r][c]) × signed(x[c]), exact in W_Y bits, sign-extended to W_Y_OUT.
  - Implementation: one MAC per row, iterating c=0..C-1, one column per cycle.
  - Results are ready C+1 cycles after the latch.
- Output packing:
  - Output bus is {y[R-1],…,y[0]}.
  - TX word j = bits [8j+7:8j], sent j=0 first, so the LSB byte of y[0] goes first.
- TX frame:
  - Start bit 0.
  - BITS_PER_WORD data bits, LSB first.
  - PACKET_SIZE_TX-BITS_PER_WORD-1 ones (4 at defaults).
  - Each bit is held CLOCKS_PER_PULSE cycles.
  - All N_WORDS_Y words are sent back-to-back; tx=1 when idle.
- Overlap:
  - RX keeps accepting bytes during compute and TX.
  - Each completed input bus is queued in a 1-deep holding register and processed once TX finishes.
  - If a third bus completes while one is still held, the new bus overwrites the held one.
  - Results are emitted in arrival order.
- Simultaneous events: rx activity never delays TX bit timing.
- Reset mid-frame: on either side, the frame is aborted immediately.

Test Plan:
1. Reset held (rstn=1) 5 cycles → tx=1 throughout; no output after release with rx idle.
2. x=[10,11,12,13] (x[0]=10); K row0=[1,2,3,4], rows1–3=0 → y0=120, others 0. TX bytes: 78 00 00 00, then 12 bytes of 00. Each frame is 0, 8 data bits, 1111.
3. Signed case: all x=0xFF (−1), all K=0x7F (127) → each y=−508. Each output is sent as bytes 04 FE FF FF, 4 times.
4. Extremes: all x=0x80, all K=0x80 (−128) → y=65536. Each output is sent as bytes 00 00 01 00.
5. Two back-to-back input vectors with random 1–20 cycle gaps between bytes → two complete 16-byte results in order, each matching its software reference.
6. Stop bit forced 0 on byte 5, then a correct resend of byte 5 → the bad byte is ignored, and the result equals that of the clean stream.
